pixel_buffer: RTL and testbench

PIXEL_BUFFER -- requirements
Module: pixel_buffer

---
 rtl/pixel_pkg.sv | 28 ++
 rtl/pixel_ram.sv | 39 +++
 rtl/pixel_buffer.sv | 177 +++++++++++++++++
 tb/tb_pixel_buffer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared constants, FSM state encoding and coordinate helper for the pixel buffer.
package pixel_pkg;

  localparam int unsigned COORD_W             = 10;
  localparam int unsigned SIZE_W              = 2;
  localparam int unsigned COLOR_W_DEFAULT     = 3;
  localparam int unsigned CLEAR_COLOR_DEFAULT = 0;

  // FSM encoding kept as plain constants so older tools can consume it.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PAINT = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_PAINT = ST_PAINT,
    S_CLEAR = ST_CLEAR
  } pixel_state_e;

  // True when an 11-bit (carry-extended) coordinate pair lies inside an h x v frame.
  function automatic logic in_frame(input logic [COORD_W:0] x,
                                    input logic [COORD_W:0] y,
                                    input int unsigned h,
                                    input int unsigned v);
    return (32'(x) < h) && (32'(y) < v);
  endfunction

endpackage

// File: rtl/pixel_ram.sv
// Simple dual-port frame store: one synchronous write port, one registered read port.
module pixel_ram
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 3,
  parameter logic [DATA_W-1:0] FILL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rvalid,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port; array contents are never reset, only swept by the owner.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register: returns pre-write data on a same-address collision, FILL when off-frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (rvalid) begin
      rdata <= mem[raddr];
    end else begin
      rdata <= FILL;
    end
  end

endmodule

// File: rtl/pixel_buffer.sv
// Frame buffer with single-pixel and square-stamp painting plus a full-frame clear sweep.
module pixel_buffer
  import pixel_pkg::*;
#(
  parameter int unsigned H_PIX   = 16,
  parameter int unsigned V_PIX   = 16,
  parameter int unsigned COLOR_W = COLOR_W_DEFAULT,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = COLOR_W'(CLEAR_COLOR_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [9:0]         rx,
  input  logic [9:0]         ry,
  output logic [COLOR_W-1:0] color_code,
  input  logic               brush,
  input  logic [9:0]         wx,
  input  logic [9:0]         wy,
  input  logic [COLOR_W-1:0] new_color,
  input  logic [1:0]         brush_size,
  input  logic               clear,
  output logic               busy
);

  localparam int unsigned DEPTH  = H_PIX * V_PIX;
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // Linear address of an in-frame pixel, row-major.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [COORD_W:0] x,
                                                 input logic [COORD_W:0] y);
    return ADDR_W'(32'(y) * H_PIX + 32'(x));
  endfunction

  logic [1:0]          state, state_n;
  logic [ADDR_W-1:0]   clr_addr, clr_addr_n;
  logic [COORD_W-1:0]  org_x, org_x_n;
  logic [COORD_W-1:0]  org_y, org_y_n;
  logic [COLOR_W-1:0]  pcolor, pcolor_n;
  logic [SIZE_W-1:0]   psize, psize_n;
  logic [SIZE_W-1:0]   dx, dx_n;
  logic [SIZE_W-1:0]   dy, dy_n;
  logic                busy_n;

  logic [COORD_W:0]    px_c, py_c;
  logic                we_c;
  logic [ADDR_W-1:0]   waddr_c;
  logic [COLOR_W-1:0]  wdata_c;
  logic                rvalid_c;
  logic [ADDR_W-1:0]   raddr_c;

  // Read address decode; off-frame reads are flagged so the RAM returns the fill colour.
  always_comb begin
    rvalid_c = in_frame({1'b0, rx}, {1'b0, ry}, H_PIX, V_PIX);
    raddr_c  = rvalid_c ? pix_addr({1'b0, rx}, {1'b0, ry}) : '0;
  end

  // State and datapath registers; reset restarts the clear sweep from address 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
      org_x    <= '0;
      org_y    <= '0;
      pcolor   <= '0;
      psize    <= '0;
      dx       <= '0;
      dy       <= '0;
      busy     <= 1'b1;
    end else begin
      state    <= state_n;
      clr_addr <= clr_addr_n;
      org_x    <= org_x_n;
      org_y    <= org_y_n;
      pcolor   <= pcolor_n;
      psize    <= psize_n;
      dx       <= dx_n;
      dy       <= dy_n;
      busy     <= busy_n;
    end
  end

  // Next-state, stamp/sweep address generation, clipping and write-port control.
  always_comb begin
    state_n    = state;
    clr_addr_n = clr_addr;
    org_x_n    = org_x;
    org_y_n    = org_y;
    pcolor_n   = pcolor;
    psize_n    = psize;
    dx_n       = dx;
    dy_n       = dy;
    we_c       = 1'b0;
    waddr_c    = '0;
    wdata_c    = CLEAR_COLOR;
    // Carry-extended so a stamp near the right/bottom edge never wraps into row/column 0.
    px_c       = {1'b0, org_x} + (COORD_W + 1)'(dx);
    py_c       = {1'b0, org_y} + (COORD_W + 1)'(dy);

    case (state)
      ST_IDLE: begin
        if (clear) begin
          state_n    = ST_CLEAR;
          clr_addr_n = '0;
        end else if (brush) begin
          if (brush_size == '0) begin
            if (in_frame({1'b0, wx}, {1'b0, wy}, H_PIX, V_PIX)) begin
              we_c    = 1'b1;
              waddr_c = pix_addr({1'b0, wx}, {1'b0, wy});
              wdata_c = new_color;
            end
          end else begin
            state_n  = ST_PAINT;
            org_x_n  = wx;
            org_y_n  = wy;
            pcolor_n = new_color;
            psize_n  = brush_size;
            dx_n     = '0;
            dy_n     = '0;
          end
        end
      end

      ST_PAINT: begin
        if (in_frame(px_c, py_c, H_PIX, V_PIX)) begin
          we_c    = 1'b1;
          waddr_c = pix_addr(px_c, py_c);
          wdata_c = pcolor;
        end
        if (dx == psize) begin
          dx_n = '0;
          if (dy == psize) begin
            state_n = ST_IDLE;
          end else begin
            dy_n = dy + SIZE_W'(1);
          end
        end else begin
          dx_n = dx + SIZE_W'(1);
        end
      end

      ST_CLEAR: begin
        we_c    = 1'b1;
        waddr_c = clr_addr;
        wdata_c = CLEAR_COLOR;
        if (clr_addr == LAST_ADDR) begin
          state_n = ST_IDLE;
        end else begin
          clr_addr_n = clr_addr + ADDR_W'(1);
        end
      end

      default: begin
        state_n    = ST_CLEAR;
        clr_addr_n = '0;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
  end

  pixel_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (COLOR_W),
    .FILL   (CLEAR_COLOR)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (we_c),
    .waddr   (waddr_c),
    .wdata   (wdata_c),
    .rvalid  (rvalid_c),
    .raddr   (raddr_c),
    .rdata   (color_code)
  );

endmodule

// File: tb/tb_pixel_buffer.sv
// Randomised bench for pixel_buffer against a queue-based frame model.
module tb_pixel_buffer;

  localparam int H   = 16;
  localparam int V   = 16;
  localparam int CW  = 3;
  localparam int CLR = 0;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [9:0]    rx = '0;
  logic [9:0]    ry = '0;
  logic [CW-1:0] color_code;
  logic          brush = 1'b0;
  logic [9:0]    wx = '0;
  logic [9:0]    wy = '0;
  logic [CW-1:0] new_color = '0;
  logic [1:0]    brush_size = '0;
  logic          clear = 1'b0;
  logic          busy;

  always #5 clk = ~clk;

  pixel_buffer #(
    .H_PIX       (H),
    .V_PIX       (V),
    .COLOR_W     (CW),
    .CLEAR_COLOR (3'(CLR))
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .ry         (ry),
    .color_code (color_code),
    .brush      (brush),
    .wx         (wx),
    .wy         (wy),
    .new_color  (new_color),
    .brush_size (brush_size),
    .clear      (clear),
    .busy       (busy)
  );

  // Model: frame contents plus the list of pixel writes still owed by a running operation.
  typedef struct {
    int x;
    int y;
    int c;
  } wr_t;

  wr_t pend[$];
  int  model[V][H];
  int  n_chk = 0;
  int  n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_clear();
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        pend.push_back('{x, y, CLR});
  endtask

  task automatic push_stamp(input int ox, input int oy, input int s, input int c);
    for (int dy = 0; dy <= s; dy++)
      for (int dx = 0; dx <= s; dx++)
        pend.push_back('{ox + dx, oy + dy, c});
  endtask

  // One clock: predict read data and busy, apply this edge's effect to the model, then compare.
  task automatic cycle();
    int  exp_rd;
    int  ix, iy;
    wr_t w;
    ix = int'(rx);
    iy = int'(ry);
    exp_rd = (ix < H && iy < V) ? model[iy][ix] : CLR;
    if (pend.size() > 0) begin
      w = pend.pop_front();
      if (w.x < H && w.y < V) model[w.y][w.x] = w.c;
    end else if (clear) begin
      push_clear();
    end else if (brush) begin
      if (brush_size == 2'd0) begin
        if (int'(wx) < H && int'(wy) < V) model[int'(wy)][int'(wx)] = int'(new_color);
      end else begin
        push_stamp(int'(wx), int'(wy), int'(brush_size), int'(new_color));
      end
    end
    @(posedge clk);
    #1;
    check("rd", int'(color_code), exp_rd);
    check("busy", int'(busy), (pend.size() > 0) ? 1 : 0);
  endtask

  // Async reset pulse starting mid-cycle; the model restarts a full clear.
  task automatic do_reset(input int hold);
    rx = 10'(H); ry = '0; brush = 1'b0; clear = 1'b0;
    reset_n = 1'b0;
    pend.delete();
    push_clear();
    #1;
    check("rst_busy", int'(busy), 1);
    check("rst_color", int'(color_code), 0);
    repeat (hold) begin
      @(posedge clk);
      #1;
      check("rst_hold_busy", int'(busy), 1);
      check("rst_hold_color", int'(color_code), 0);
    end
    reset_n = 1'b1;
  endtask

  // Run cycles until busy drops and compare the number of busy cycles.
  task automatic wait_idle(input string tag, input int exp);
    int cnt;
    cnt = 0;
    do begin
      cycle();
      cnt++;
    end while (busy && cnt < exp + 20);
    check(tag, cnt, exp);
  endtask

  task automatic read_px(input string tag, input int x, input int y, input int exp);
    rx = 10'(x); ry = 10'(y);
    cycle();
    check(tag, int'(color_code), exp);
  endtask

  task automatic frame_check();
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        rx = 10'(x); ry = 10'(y);
        cycle();
      end
  endtask

  task automatic set_brush(input int x, input int y, input int s, input int c);
    brush = 1'b1; wx = 10'(x); wy = 10'(y); brush_size = 2'(s); new_color = 3'(c);
  endtask

  initial begin
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        model[y][x] = 7;

    @(posedge clk);
    #1;
    do_reset(3);
    wait_idle("rst_sweep", H * V);
    frame_check();

    // 1x1 brush with a same-cycle read of the target pixel.
    set_brush(3, 4, 0, 5);
    rx = 10'd3; ry = 10'd4;
    cycle();
    brush = 1'b0;
    read_px("px_3_4", 3, 4, 5);

    // Off-frame 1x1 brush is dropped.
    set_brush(16, 0, 0, 4);
    rx = 10'd0; ry = 10'd0;
    cycle();
    brush = 1'b0;
    read_px("oob_brush", 0, 0, CLR);

    // 3x3 stamp clipped at the bottom-right corner.
    set_brush(14, 14, 2, 6);
    cycle();
    brush = 1'b0;
    wait_idle("paint9", 9);
    read_px("px_14_14", 14, 14, 6);
    read_px("px_15_15", 15, 15, 6);
    read_px("nowrap_0_14", 0, 14, CLR);
    read_px("nowrap_14_0", 14, 0, CLR);
    frame_check();

    // Clear wins over a simultaneous brush; requests during the sweep are ignored.
    set_brush(1, 1, 0, 7);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    rx = 10'd20; ry = 10'd2;
    wait_idle("clr256", H * V);
    brush = 1'b0;
    read_px("oob_rx", 20, 2, CLR);
    read_px("oob_ry", 5, 30, CLR);
    read_px("px_3_4_cleared", 3, 4, CLR);
    frame_check();

    // Reset during a 4x4 stamp aborts it and restarts the sweep.
    set_brush(2, 2, 3, 3);
    cycle();
    brush = 1'b0;
    repeat (3) cycle();
    do_reset(2);
    wait_idle("rst_mid", H * V);
    frame_check();

    // Random traffic, reads biased toward the brush area to provoke collisions.
    for (int i = 0; i < 1500; i++) begin
      brush      = ($urandom_range(0, 1) == 1);
      clear      = ($urandom_range(0, 99) == 0);
      wx         = 10'($urandom_range(0, 19));
      wy         = 10'($urandom_range(0, 19));
      brush_size = 2'($urandom_range(0, 3));
      new_color  = 3'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        rx = wx; ry = wy;
      end else begin
        rx = 10'($urandom_range(0, 19));
        ry = 10'($urandom_range(0, 19));
      end
      cycle();
    end
    brush = 1'b0;
    clear = 1'b0;
    for (int i = 0; i < 400 && pend.size() > 0; i++) cycle();
    frame_check();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
